// File: rtl/id_pkg.sv
// Shared encodings and the instruction decoder for the id_pipe decode stage.
package id_pkg;

  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;

  localparam logic [5:0] EXE_AND = 6'b100100;
  localparam logic [5:0] EXE_OR  = 6'b100101;
  localparam logic [5:0] EXE_XOR = 6'b100110;
  localparam logic [5:0] EXE_NOR = 6'b100111;
  localparam logic [5:0] EXE_SLL = 6'b000000;
  localparam logic [5:0] EXE_SRL = 6'b000010;
  localparam logic [5:0] EXE_SRA = 6'b000011;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  // How the immediate operand is formed; widening to DATA_W happens in the top.
  typedef enum logic [1:0] {
    IMM_NONE   = 2'd0,
    IMM_ZEXT16 = 2'd1,
    IMM_LUI    = 2'd2,
    IMM_SA     = 2'd3
  } imm_kind_e;

  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic [4:0] wd;
    logic       wreg;
    logic       re1;
    logic       re2;
    imm_kind_e  imm_kind;
    logic       invalid;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d.aluop    = EXE_NOP_OP;
    d.alusel   = EXE_RES_NOP;
    d.wd       = inst[15:11];
    d.wreg     = 1'b0;
    d.re1      = 1'b0;
    d.re2      = 1'b0;
    d.imm_kind = IMM_NONE;
    d.invalid  = 1'b1;
    case (inst[31:26])
      EXE_ORI, EXE_ANDI, EXE_XORI, EXE_LUI: begin
        d.re1      = 1'b1;
        d.wd       = inst[20:16];
        d.wreg     = 1'b1;
        d.alusel   = EXE_RES_LOGIC;
        d.invalid  = 1'b0;
        d.imm_kind = (inst[31:26] == EXE_LUI) ? IMM_LUI : IMM_ZEXT16;
        case (inst[31:26])
          EXE_ANDI: d.aluop = EXE_AND_OP;
          EXE_XORI: d.aluop = EXE_XOR_OP;
          default:  d.aluop = EXE_OR_OP;
        endcase
      end
      EXE_SPECIAL: begin
        if (inst[10:6] == 5'd0) begin
          case (inst[5:0])
            EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
              d.re1     = 1'b1;
              d.re2     = 1'b1;
              d.wreg    = 1'b1;
              d.alusel  = EXE_RES_LOGIC;
              d.invalid = 1'b0;
              d.aluop   = {2'b00, inst[5:0]};
            end
            default: ;
          endcase
        end
        if (inst[25:21] == 5'd0) begin
          case (inst[5:0])
            EXE_SLL, EXE_SRL, EXE_SRA: begin
              d.re2      = 1'b1;
              d.wreg     = 1'b1;
              d.imm_kind = IMM_SA;
              d.alusel   = EXE_RES_SHIFT;
              d.invalid  = 1'b0;
              d.aluop    = (inst[5:0] == EXE_SLL) ? EXE_SLL_OP :
                           (inst[5:0] == EXE_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand select for one register-file read port plus its hazard-match term.
// Forwarding is enabled by defining ID_FORWARD_EN.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_read_en,
  input  logic [4:0]        i_addr,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_ex_wreg,
  input  logic [4:0]        i_ex_wd,
  input  logic [DATA_W-1:0] i_ex_wdata,
  input  logic              i_ex_is_load,
  input  logic              i_mem_wreg,
  input  logic [4:0]        i_mem_wd,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard
);

  logic w_nz;
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_nz      = (i_addr != NOP_REG_ADDR);
  assign w_ex_hit  = w_nz && i_ex_wreg  && (i_ex_wd  == i_addr);
  assign w_mem_hit = w_nz && i_mem_wreg && (i_mem_wd == i_addr);

`ifdef ID_FORWARD_EN
  always_comb begin
    // NOTE: every output gets a value on every path of an always_comb, else a latch is inferred.
    o_data = i_reg_data;
    if (!i_read_en)     o_data = i_imm;
    else if (!w_nz)     o_data = '0;
    else if (w_ex_hit)  o_data = i_ex_wdata;
    else if (w_mem_hit) o_data = i_mem_wdata;
  end
  // Only a load still in EX has no data yet; everything else is forwarded.
  assign o_hazard = i_read_en && w_ex_hit && i_ex_is_load;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_ex_wdata, i_mem_wdata, i_ex_is_load};

  always_comb begin
    o_data = i_reg_data;
    if (!i_read_en) o_data = i_imm;
    else if (!w_nz) o_data = '0;
  end
  // Without bypass paths, wait until the producer has written the register file.
  assign o_hazard = i_read_en && (w_ex_hit || w_mem_hit);
`endif

endmodule

// File: rtl/id_pipe.sv
// Decode stage with registered ID/EX output, valid/ready handshake and load-use
// interlock. Define ID_FORWARD_EN to enable EX/MEM operand forwarding.
module id_pipe
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [4:0]          reg1_addr_o,
  output logic [4:0]          reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [4:0]          ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [4:0]          mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [PC_W-1:0]     pc_o,
  output logic                inst_invalid_o
);

  dec_t              w_dec;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_reg1;
  logic [DATA_W-1:0] w_reg2;
  logic              w_haz1;
  logic              w_haz2;
  logic              w_stall;
  logic              w_adv;
  logic              w_accept;

  logic                r_out_valid;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [4:0]          r_wd;
  logic                r_wreg;
  logic [PC_W-1:0]     r_pc;
  logic                r_invalid;

  assign w_dec = decode(inst_i);

  always_comb begin
    case (w_dec.imm_kind)
      IMM_ZEXT16: w_imm = DATA_W'(inst_i[15:0]);
      IMM_LUI:    w_imm = DATA_W'({inst_i[15:0], 16'h0000});
      IMM_SA:     w_imm = DATA_W'(inst_i[10:6]);
      default:    w_imm = '0;
    endcase
  end

  assign reg1_read_o = w_dec.re1;
  assign reg2_read_o = w_dec.re2;
  assign reg1_addr_o = inst_i[25:21];
  assign reg2_addr_o = inst_i[20:16];

  id_fwd_mux #(.DATA_W(DATA_W)) u_fwd1 (
    .i_read_en    (w_dec.re1),
    .i_addr       (inst_i[25:21]),
    .i_imm        (w_imm),
    .i_reg_data   (reg1_data_i),
    .i_ex_wreg    (ex_wreg_i),
    .i_ex_wd      (ex_wd_i),
    .i_ex_wdata   (ex_wdata_i),
    .i_ex_is_load (ex_is_load_i),
    .i_mem_wreg   (mem_wreg_i),
    .i_mem_wd     (mem_wd_i),
    .i_mem_wdata  (mem_wdata_i),
    .o_data       (w_reg1),
    .o_hazard     (w_haz1)
  );

  id_fwd_mux #(.DATA_W(DATA_W)) u_fwd2 (
    .i_read_en    (w_dec.re2),
    .i_addr       (inst_i[20:16]),
    .i_imm        (w_imm),
    .i_reg_data   (reg2_data_i),
    .i_ex_wreg    (ex_wreg_i),
    .i_ex_wd      (ex_wd_i),
    .i_ex_wdata   (ex_wdata_i),
    .i_ex_is_load (ex_is_load_i),
    .i_mem_wreg   (mem_wreg_i),
    .i_mem_wd     (mem_wd_i),
    .i_mem_wdata  (mem_wdata_i),
    .o_data       (w_reg2),
    .o_hazard     (w_haz2)
  );

  assign w_stall  = in_valid && (w_haz1 || w_haz2);
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv && !w_stall && !flush_i && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_aluop     <= '0;
      r_alusel    <= '0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_pc        <= '0;
      r_invalid   <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      // A stall lands here with w_accept low: bubble out, payload kept.
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_aluop   <= ALUOP_W'(w_dec.aluop);
        r_alusel  <= ALUSEL_W'(w_dec.alusel);
        r_reg1    <= w_reg1;
        r_reg2    <= w_reg2;
        r_wd      <= w_dec.wd;
        r_wreg    <= w_dec.wreg;
        r_pc      <= pc_i;
        r_invalid <= w_dec.invalid;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_invalid;

endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised decode stage with a registered ID/EX output, valid/ready handshake, EX/MEM operand forwarding and load-use interlock. It sits between the IF/ID register and the EX stage, and drives the register-file read ports combinationally. It decodes ORI/ANDI/XORI/LUI and the SPECIAL logic and shift group (AND/OR/XOR/NOR/SLL/SRL/SRA). Its outputs are captured in an internal pipeline register, so the ID/EX register is absorbed into this block.

## Interface
- DATA_W, 32, operand/immediate width; immediates are extended to DATA_W (must be ≥32)
- PC_W, 32, instruction address width
- ALUOP_W, 8, aluop field width
- ALUSEL_W, 3, alusel field width
- clk in 1: rising-edge clock
- rst in 1: reset, synchronous, active-high
- in_valid in 1: pc_i/inst_i valid
- in_ready out 1: instruction accepted this cycle when in_valid & in_ready
- pc_i in PC_W: instruction address
- inst_i in 32: instruction word
- reg1_read_o, reg2_read_o out 1: register-file read enables (combinational)
- reg1_addr_o, reg2_addr_o out 5: rs = inst_i[25:21], rt = inst_i[20:16] (combinational)
- reg1_data_i, reg2_data_i in DATA_W: register-file read data, same cycle
- ex_wreg_i, ex_wd_i[4:0], ex_wdata_i[DATA_W], ex_is_load_i: EX-stage write-back info
- mem_wreg_i, mem_wd_i[4:0], mem_wdata_i[DATA_W]: MEM-stage write-back info
- flush_i in 1: discard the registered and incoming instruction
- out_valid out 1: ID/EX contents valid
- out_ready in 1: EX accepts the contents
- aluop_o out ALUOP_W, alusel_o out ALUSEL_W, reg1_o/reg2_o out DATA_W, wd_o out 5, wreg_o out 1, pc_o out PC_W, inst_invalid_o out 1: registered decode results

## Operation
- **Decode, combinational.** Defaults: aluop NOP, alusel NOP, wd = inst[15:11], wreg 0, both read enables 0, imm 0, invalid 1.
- **ORI/ANDI/XORI.**
  - Read rs.
  - imm = zero-extended inst[15:0].
  - wd = rt, wreg 1.
  - alusel LOGIC; aluop OR/AND/XOR.
- **LUI.**
  - Read rs.
  - imm = {inst[15:0], 16'h0}, zero-extended to DATA_W.
  - aluop OR, wd = rt.
- **SPECIAL (op 0), inst[10:6] = 0.** funct 100100/100101/100110/100111 → AND/OR/XOR/NOR. Reads rs and rt, wd = rd, alusel LOGIC.
- **SPECIAL SLL/SRL/SRA (funct 000000/000010/000011, rs = 0).**
  - Read rt only.
  - imm = zero-extended sa (inst[10:6]).
  - wd = rd, alusel SHIFT.
  - The all-zero word decodes as SLL $0 and is valid.
- **Unmatched encoding.** Produces the defaults with inst_invalid_o = 1 and is still passed down the pipeline.
- **Operand select, per port.**
  - Read disabled: imm.
  - Read enabled:
    - address 0: zero;
    - else EX match (ex_wreg_i & ex_wd_i == addr): ex_wdata_i;
    - else MEM match: mem_wdata_i;
    - else reg*_data_i.
  - EX has priority over MEM.
- **Hazard.** stall = in_valid & an enabled, nonzero source equals ex_wd_i while ex_wreg_i & ex_is_load_i.
- **Handshake.**
  - adv = !out_valid | out_ready.
  - in_ready = adv & !stall & !flush_i.
  - On adv:
    - out_valid ← in_valid & !stall & !flush_i.
    - If an instruction is accepted, the payload is loaded.
    - If stalled, a bubble is inserted (out_valid 0, payload unchanged).
  - On !adv all registers hold.
- **flush_i.** Highest priority: out_valid ← 0 next edge and in_ready = 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid = 1 after edge N.
- Throughput is 1 instruction/cycle with no hazards.
- A load-use pair costs exactly 1 bubble. The stall releases when the load leaves EX; its data is then taken from the MEM-forward path.
- Reset values: out_valid 0, aluop 0 (NOP), alusel 0 (NOP), reg1_o 0, reg2_o 0, wd_o 0, wreg_o 0, pc_o 0, inst_invalid_o 0.
- While rst is high, in_ready = 0.
- Reset asserted mid-stall or mid-backpressure clears everything at the next edge; the held instruction is lost, and the upstream stage replays it.
- Forwarding data must be stable within the same cycle. The path is combinational from ex_wdata_i to the ID/EX register D input.

## Configuration
- ID_FORWARD_EN defined: forwarding as above; stall only on load-use.
- ID_FORWARD_EN undefined:
  - No forward muxes; operands come from reg*_data_i only.
  - stall = any enabled, nonzero source matching an EX or MEM destination with wreg set.
  - The register file must write through in the write-back cycle.

## Structure
- Package id_pkg:
  - opcode constants: EXE_ORI 001101, ANDI 001100, XORI 001110, LUI 001111, SPECIAL 000000.
  - funct constants.
  - aluop codes: NOP 00000000, AND 00100100, OR 00100101, XOR 00100110, NOR 00100111, SLL 01111100, SRL 00000010, SRA 00000011.
  - alusel codes: NOP 000, LOGIC 001, SHIFT 010.
  - NOPRegAddr 0.
- Sub-module id_fwd_mux, one instance per operand: priority select plus hazard-match term.

## Test plan
- **ORI.** ORI $1,$0,0x1100 with regfile data 0 → next cycle: out_valid 1, aluop OR, alusel LOGIC, reg1_o 0, reg2_o 0x00001100, wd_o 1, wreg_o 1.
- **EX forward.** OR $3,$1,$2 with EX writing $1 = 0xDEADBEEF and MEM writing $1 = 0x5 → reg1_o 0xDEADBEEF (EX priority); reg2_o from regfile.
- **Load-use.** ex_is_load_i with ex_wd_i = 4, followed by ANDI $5,$4,0xFF → in_ready 0 for 1 cycle, one bubble (out_valid 0). Next cycle, with the MEM forward of 0x1234, reg1_o = 0x1234.
- **Backpressure.** out_ready held 0 for 3 cycles → out_valid and payload held, in_ready 0; release → normal flow resumes with no loss and no duplication.
- **Flush.** flush_i pulsed while out_valid = 1 with in_valid = 1 → out_valid 0 next edge; the input is not accepted.
- **Invalid and reset.** inst 0xFC000000 → inst_invalid_o 1, wreg_o 0. rst asserted mid-stall → all outputs at reset values next edge.
- **Macro off.** Build without ID_FORWARD_EN: the EX-match case stalls until the producer leaves MEM; the operand then comes from regfile data.
